// File: rtl/reg_cmd_fifo_pkg.sv
// ---------------------------------------------------------------------------
// reg_cmd_pkg
// Shared types for the register-write command queue.
//   regname_e      : target register name, REG0..REG3
//   REG_CMD_DATA_W : default data word width
//   reg_cmd_t      : one stored command (register name + data word)
// The register-name field is called 'rname' because 'reg' is a reserved word.
// ---------------------------------------------------------------------------
package reg_cmd_pkg;

   typedef enum logic [1:0] {
      REG0 = 2'd0,
      REG1 = 2'd1,
      REG2 = 2'd2,
      REG3 = 2'd3
   } regname_e;

   localparam int REG_CMD_DATA_W = 8;

   typedef struct packed {
      regname_e                  rname;
      logic [REG_CMD_DATA_W-1:0] data;
   } reg_cmd_t;

endpackage

// File: rtl/reg_cmd_fifo_match.sv
// ---------------------------------------------------------------------------
// reg_cmd_match
// Membership lookup over the command storage: reports whether any occupied
// entry targets the queried register.
// Ports:
//   entry_reg  in  register name held in each storage slot
//   occupied   in  one bit per slot, set when the slot holds a live command
//   query_reg  in  register name to look up
//   query_hit  out at least one occupied slot matches query_reg
// ---------------------------------------------------------------------------
module reg_cmd_match
   import reg_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0][1:0] entry_reg,
   input  logic [DEPTH-1:0]      occupied,
   input  regname_e              query_reg,
   output logic                  query_hit
);

   // OR-reduce the per-slot matches; slots outside the occupied window are
   // masked off so stale data left behind by earlier pops never matches.
   always_comb begin
      query_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occupied[i] && (entry_reg[i] == query_reg)) begin
            query_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_cmd_fifo.sv
// ---------------------------------------------------------------------------
// reg_cmd_fifo
// Buffered queue of register-write commands (register name + data word)
// with valid/ready on both sides and a combinational "is register X pending"
// lookup over the occupied entries.
// Optional build macro: REG_CMD_FIFO_BYPASS_EN
//   defined   : when the queue is empty the input is forwarded straight to
//               the output in the same cycle; it is only stored if the
//               consumer does not take it.
//   undefined : output always comes from storage (one cycle latency).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake
//   in_reg/in_data       incoming command
//   out_valid/out_ready  downstream handshake
//   out_reg/out_data     head command (REG0 / 0 when out_valid is low)
//   query_reg/query_hit  pending-register lookup (storage only)
//   count                number of occupied entries
// ---------------------------------------------------------------------------
module reg_cmd_fifo
   import reg_cmd_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  regname_e                 in_reg,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output regname_e                 out_reg,
   output logic [DATA_W-1:0]        out_data,
   input  regname_e                 query_reg,
   output logic                     query_hit,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count_q;
   logic                    fifo_valid;
   logic                    bypass_active;
   logic                    push;
   logic                    pop;
   logic                    do_write;
   logic                    do_read;
   logic [DEPTH-1:0][1:0]   entry_reg;
   logic [DEPTH-1:0]        occupied;
   logic [PTR_W-1:0]        slot_offset;
   regname_e                head_reg;
   logic [DATA_W-1:0]       head_data;

   assign count      = count_q;
   assign fifo_valid = (count_q != '0);
   assign in_ready   = (count_q != CNT_W'(DEPTH));

   // The bypass window is open only while nothing is stored, so forwarded
   // commands can never overtake queued ones.
   always_comb begin
      bypass_active = 1'b0;
`ifdef REG_CMD_FIFO_BYPASS_EN
      bypass_active = (count_q == '0);
`endif
   end

   // Output mux: forwarded input in the bypass window, otherwise the head
   // slot; idle output is forced to REG0 / 0.
   always_comb begin
      out_valid = fifo_valid;
      out_reg   = REG0;
      out_data  = '0;
      if (bypass_active) begin
         out_valid = in_valid;
         if (in_valid) begin
            out_reg  = in_reg;
            out_data = in_data;
         end
      end else if (fifo_valid) begin
         out_reg  = head_reg;
         out_data = head_data;
      end
   end

   // A command taken straight through the bypass never touches storage, so
   // it neither writes a slot nor advances the read pointer.
   always_comb begin
      push     = in_valid && in_ready;
      pop      = out_valid && out_ready;
      do_write = push && !(bypass_active && out_ready);
      do_read  = pop && !bypass_active;
   end

   // Pointer and occupancy bookkeeping; a simultaneous write and read leaves
   // the count alone while both pointers advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_write, do_read})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage. The packed command struct is used when the data width matches
   // the package default; otherwise name and data live in separate arrays.
   generate
      if (DATA_W == REG_CMD_DATA_W) begin : g_struct
         reg_cmd_t mem [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem[i] <= '0;
               end
            end else if (do_write) begin
               mem[wr_ptr] <= '{rname: in_reg, data: REG_CMD_DATA_W'(in_data)};
            end
         end

         assign head_reg  = mem[rd_ptr].rname;
         assign head_data = DATA_W'(mem[rd_ptr].data);

         for (genvar g = 0; g < DEPTH; g++) begin : g_view
            assign entry_reg[g] = mem[g].rname;
         end
      end else begin : g_split
         regname_e          reg_mem  [DEPTH];
         logic [DATA_W-1:0] data_mem [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  reg_mem[i]  <= REG0;
                  data_mem[i] <= '0;
               end
            end else if (do_write) begin
               reg_mem[wr_ptr]  <= in_reg;
               data_mem[wr_ptr] <= in_data;
            end
         end

         assign head_reg  = reg_mem[rd_ptr];
         assign head_data = data_mem[rd_ptr];

         for (genvar g = 0; g < DEPTH; g++) begin : g_view
            assign entry_reg[g] = reg_mem[g];
         end
      end
   endgenerate

   // A slot is live when its distance from the read pointer (modulo DEPTH)
   // is below the current count; this handles the wrapped window naturally.
   always_comb begin
      occupied    = '0;
      slot_offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_offset = PTR_W'(i) - rd_ptr;
         occupied[i] = ({1'b0, slot_offset} < count_q);
      end
   end

   reg_cmd_match #(
      .DEPTH (DEPTH)
   ) u_match (
      .entry_reg (entry_reg),
      .occupied  (occupied),
      .query_reg (query_reg),
      .query_hit (query_hit)
   );

endmodule

// File: tb/tb_reg_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tb_reg_cmd_fifo
// Directed self-checking bench for reg_cmd_fifo (DEPTH=4, DATA_W=8).
// Bypass-dependent expectations follow REG_CMD_FIFO_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_reg_cmd_fifo;
   import reg_cmd_pkg::*;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   regname_e   in_reg;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   regname_e   out_reg;
   logic [7:0] out_data;
   regname_e   query_reg;
   logic       query_hit;
   logic [2:0] count;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   int         exp_count;
   logic       exp_push;
   logic [7:0] d;

   reg_cmd_fifo #(
      .DEPTH  (4),
      .DATA_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_reg    (in_reg),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_reg   (out_reg),
      .out_data  (out_data),
      .query_reg (query_reg),
      .query_hit (query_hit),
      .count     (count)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and come back to the falling edge for sampling.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive one set of upstream/downstream inputs.
   task automatic applyStimulus(input logic v, input regname_e r,
                                input logic [7:0] dat, input logic rdy);
      in_valid  = v;
      in_reg    = r;
      in_data   = dat;
      out_ready = rdy;
   endtask

   // One comparison: counts it, and reports it if observed differs.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, REG0, 8'h00, 1'b0);
      query_reg = REG0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_out_reg", out_reg, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_query_hit", query_hit, 0);

      // Single push {REG2, A5} with consumer stalled
      applyStimulus(1'b1, REG2, 8'hA5, 1'b0);
      query_reg = REG2;
      #1;
`ifdef REG_CMD_FIFO_BYPASS_EN
      checkOutput("push_cycle_out_valid", out_valid, 1);
`else
      checkOutput("push_cycle_out_valid", out_valid, 0);
`endif
      checkOutput("push_cycle_query_hit", query_hit, 0);
      tick();
      applyStimulus(1'b0, REG0, 8'h00, 1'b0);
      #1;
      checkOutput("one_out_valid", out_valid, 1);
      checkOutput("one_out_reg", out_reg, 2);
      checkOutput("one_out_data", out_data, 8'hA5);
      checkOutput("one_count", count, 1);
      checkOutput("one_query_hit", query_hit, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      checkOutput("one_drained_count", count, 0);

      // Fill REG0..REG3 with data 1..4
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, regname_e'(i), 8'(i + 1), 1'b0);
         tick();
      end
      checkOutput("full_count", count, 4);
      checkOutput("full_in_ready", in_ready, 0);
      applyStimulus(1'b1, REG1, 8'h99, 1'b0);
      tick();
      checkOutput("full_ignored_count", count, 4);
      checkOutput("full_head_data", out_data, 1);
      applyStimulus(1'b0, REG0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("drain_data", out_data, i + 1);
         checkOutput("drain_reg", out_reg, i);
         tick();
      end
      out_ready = 1'b0;
      #1;
      checkOutput("drain_count", count, 0);
      checkOutput("drain_out_valid", out_valid, 0);

      // Fill to 4, then 10 cycles of push+pop; the pointers wrap
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         d = 8'(8'h0A + i);
         applyStimulus(1'b1, regname_e'(d[1:0]), d, 1'b0);
         exp_q.push_back(d);
         tick();
      end
      exp_count = 4;
      for (int k = 0; k < 10; k++) begin
         d = 8'(8'h20 + k);
         applyStimulus(1'b1, regname_e'(d[1:0]), d, 1'b1);
         #1;
         exp_push = (exp_count != 4);
         checkOutput("stream_in_ready", in_ready, exp_push);
         checkOutput("stream_head_data", out_data, exp_q[0]);
         checkOutput("stream_head_reg", out_reg, exp_q[0][1:0]);
         if (exp_push) exp_q.push_back(d);
         void'(exp_q.pop_front());
         if (!exp_push) exp_count--;
         tick();
         checkOutput("stream_count", count, exp_count);
      end
      applyStimulus(1'b0, REG0, 8'h00, 1'b1);
      while (exp_q.size() > 0) begin
         #1;
         checkOutput("stream_tail_data", out_data, exp_q[0]);
         void'(exp_q.pop_front());
         tick();
      end
      out_ready = 1'b0;
      #1;
      checkOutput("stream_empty_count", count, 0);

      // Membership query over {REG1}, {REG3}
      applyStimulus(1'b1, REG1, 8'h11, 1'b0);
      tick();
      applyStimulus(1'b1, REG3, 8'h33, 1'b0);
      tick();
      applyStimulus(1'b0, REG0, 8'h00, 1'b0);
      query_reg = REG3;
      #1;
      checkOutput("query_reg3_hit", query_hit, 1);
      query_reg = REG0;
      #1;
      checkOutput("query_reg0_miss", query_hit, 0);
      query_reg = REG1;
      #1;
      checkOutput("query_reg1_hit", query_hit, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      checkOutput("query_reg1_popped", query_hit, 0);
      query_reg = REG3;
      #1;
      checkOutput("query_reg3_still", query_hit, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      checkOutput("query_drained_count", count, 0);

`ifdef REG_CMD_FIFO_BYPASS_EN
      // Pass-through while empty
      applyStimulus(1'b1, REG0, 8'h3C, 1'b1);
      query_reg = REG0;
      #1;
      checkOutput("bypass_out_valid", out_valid, 1);
      checkOutput("bypass_out_data", out_data, 8'h3C);
      checkOutput("bypass_query_hit", query_hit, 0);
      tick();
      applyStimulus(1'b0, REG0, 8'h00, 1'b0);
      #1;
      checkOutput("bypass_count", count, 0);
`endif

      // Asynchronous reset mid-stream with three entries queued
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, REG2, 8'(8'h41 + i), 1'b0);
         tick();
      end
      checkOutput("pre_rst_count", count, 3);
      applyStimulus(1'b1, REG3, 8'h77, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_count", count, 0);
      checkOutput("async_rst_in_ready", in_ready, 1);
      in_valid = 1'b0;
      #1;
      checkOutput("async_rst_out_valid", out_valid, 0);
      checkOutput("async_rst_out_reg", out_reg, 0);
      checkOutput("async_rst_out_data", out_data, 0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, REG1, 8'h5A, 1'b0);
      tick();
      applyStimulus(1'b0, REG0, 8'h00, 1'b0);
      #1;
      checkOutput("post_rst_out_valid", out_valid, 1);
      checkOutput("post_rst_out_reg", out_reg, 1);
      checkOutput("post_rst_out_data", out_data, 8'h5A);
      checkOutput("post_rst_count", count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
